tinyodin_obi_responder: RTL and testbench
=========================================

Name: tinyodin_obi_responder

Overview:
- OBI slave front-end of tinyODIN; the responder end of the OBI bus the host drives.
- Decodes each request into one of four regions: spike core, neuron core, synapse core or control register.
- Drives the single-port SRAM strobes for the addressed region and returns the OBI grant/response with fixed latency.
- Holds the control register, issues the core start pulse, and stalls SRAM-region accesses while the core is running.

Parameters:
N, 256, neuron count; neuron index width = $clog2(N) = 8
SPK_AW, 6, spike-core word address width (64 words)
SYN_AW, 13, synapse-core word address width (8192 words)
req_t, obi_pkg::obi_req_t, OBI request struct type (req, we, be, addr, wdata)
rsp_t, obi_pkg::obi_resp_t, OBI response struct type (gnt, rvalid, rdata)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
tinyODIN_slave_req_i  in  req_t  OBI request
tinyODIN_slave_resp_o  out  rsp_t  OBI response
spk_cs_o / spk_we_o  out  1/1  spike SRAM chip select / write enable
spk_addr_o  out  SPK_AW  spike SRAM word address
neur_cs_o / neur_we_o  out  1/1  neuron SRAM chip select / write enable
neur_addr_o  out  8  neuron SRAM word address
syn_cs_o / syn_we_o  out  1/1  synapse SRAM chip select / write enable
syn_addr_o  out  SYN_AW  synapse SRAM word address
mem_wdata_o  out  32  shared SRAM write data
spk_rdata_i / neur_rdata_i / syn_rdata_i  in  32 each  SRAM read data, valid 1 cycle after cs
ctrl_o  out  32  control register contents
start_o  out  1  one-cycle core start pulse
core_busy_i  in  1  core is processing

Behaviour:
- Address decode:
  - addr[21:20] selects the region: 00 spike, 01 neuron, 10 synapse, 11 control.
  - Word index is taken from addr[2+AW-1:2]: spike [7:2], neuron [9:2], synapse [14:2]; control ignores addr[19:0].
  - addr[31:22] != 0 is unmapped.
- be is ignored; every write is a full 32-bit word.
- States: IDLE (no response pending) and RESP (rvalid is due this cycle). One outstanding transaction maximum.
- Grant:
  - gnt is combinational and equals req, except gnt=0 when core_busy_i=1 and the target region is spike, neuron or synapse.
  - Control and unmapped accesses are always granted.
  - A request seen in RESP may be granted in the same cycle (back-to-back throughput of 1 transaction per cycle).
- On a granted request (cycle 0):
  - The selected region's cs and we are driven combinationally in cycle 0, with mem_wdata_o = wdata; all other cs stay 0.
  - The request's region, we and unmapped flag are registered.
- Response (cycle 1): rvalid=1 for exactly one cycle. rdata by case:
  - SRAM read: the selected region's rdata_i.
  - Control read: {ctrl[31:11], core_busy_i, ctrl[9:0]}.
  - Write: 0.
  - Unmapped read: 32'hDEAD_BEEF; no SRAM touched.
- Control write (granted, cycle 0):
  - ctrl[31:11] and ctrl[9:0] load from wdata in cycle 1.
  - ctrl[10] is START: it is never stored and reads back as busy.
  - If wdata[10]=1 and core_busy_i=0, start_o=1 in cycle 1 only. If core_busy_i=1, the START bit is dropped and the other fields are still written.
- Stall: while gnt=0 the request is held by the master; no cs asserted, no state change.
- Reset values: gnt=0, rvalid=0, rdata=0, all cs/we=0, addr outputs 0, mem_wdata_o=0, ctrl_o=0, start_o=0; state IDLE.
- Reset mid-transaction: a pending rvalid is dropped; nothing is returned for the in-flight request.
- rdata holds its last value when rvalid=0.

Decomposition:
- Shared package tinyodin_pkg:
  - region enum {REG_SPK, REG_NEUR, REG_SYN, REG_CTRL};
  - constants REGION_LSB=20, CTRL_START_BIT=10, UNMAPPED_RDATA=32'hDEAD_BEEF;
  - ctrl field widths.
- One sub-module, tinyodin_addr_decode (combinational): outputs region, word index and unmapped flag; everything else stays in the top.

Test Plan:
1. Write neuron addr 0x0010_03FC, wdata 0x0015_E000 -> cycle 0: neur_cs=1, neur_we=1, neur_addr=0xFF; cycle 1: rvalid=1, rdata=0.
2. Read synapse addr 0x0020_4878 (index 4638) with SRAM returning 0x1234_5678 -> syn_cs=1, syn_we=0, syn_addr=4638; next cycle rvalid=1, rdata=0x1234_5678.
3. Write control 0x0030_0000 = 0xFF00_0400 with busy=0 -> start_o=1 for one cycle; ctrl_o=0xFF00_0000. Then raise busy and read control -> rdata=0xFF00_0400.
4. busy=1, spike write to 0x0000_0010 -> gnt=0, spk_cs=0 while busy; drop busy -> gnt=1 same cycle, spk_addr=4.
5. Back-to-back: 64 spike writes, req held high continuously -> 64 gnt cycles, 64 rvalid pulses, each rvalid exactly one cycle after its gnt.
6. Read 0x0040_0000 -> gnt=1, no cs; rdata=0xDEAD_BEEF. Assert RST during a pending response -> rvalid=0 next cycle and all outputs at reset values.

Source files
------------

// File: rtl/obi_pkg.sv
// OBI bus payload types shared by the host side and the tinyODIN responder.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/tinyodin_pkg.sv
// Address map, control register layout and FSM types for the tinyODIN OBI responder.
package tinyodin_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned REGION_W       = 2;
    localparam int unsigned REGION_LSB     = 20;
    localparam int unsigned MAP_LSB        = 22;
    localparam int unsigned WORD_LSB       = 2;
    localparam int unsigned CTRL_START_BIT = 10;
    localparam int unsigned CTRL_HI_W      = DATA_W - CTRL_START_BIT - 1;
    localparam int unsigned CTRL_LO_W      = CTRL_START_BIT;

    localparam logic [DATA_W-1:0] UNMAPPED_RDATA  = 32'hDEAD_BEEF;
    localparam logic [DATA_W-1:0] CTRL_START_MASK = DATA_W'(1) << CTRL_START_BIT;

    typedef enum logic [REGION_W-1:0] {
        REG_SPK  = 2'd0,
        REG_NEUR = 2'd1,
        REG_SYN  = 2'd2,
        REG_CTRL = 2'd3
    } region_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // Control register as seen by the host: START position reports core busy.
    function automatic logic [DATA_W-1:0] ctrl_view(input logic [DATA_W-1:0] ctrl,
                                                    input logic busy);
        return (ctrl & ~CTRL_START_MASK) | (busy ? CTRL_START_MASK : '0);
    endfunction

endpackage

// File: rtl/tinyodin_addr_decode.sv
// Splits an OBI byte address into target region, per-region word index and unmapped flag.
module tinyodin_addr_decode
    import tinyodin_pkg::*;
#(
    parameter int unsigned SPK_AW  = 6,
    parameter int unsigned NEUR_AW = 8,
    parameter int unsigned SYN_AW  = 13
) (
    input  logic [DATA_W-1:0]  addr,
    output region_t            region,
    output logic               unmapped,
    output logic [SPK_AW-1:0]  spk_idx,
    output logic [NEUR_AW-1:0] neur_idx,
    output logic [SYN_AW-1:0]  syn_idx
);

    // Bits outside the decoded fields are don't-care by design.
    logic unused_addr;
    assign unused_addr = ^addr;

    // Pure field extraction; region bits are meaningless when unmapped is set.
    always_comb begin
        region   = region_t'(addr[REGION_LSB +: REGION_W]);
        unmapped = |addr[DATA_W-1:MAP_LSB];
        spk_idx  = addr[WORD_LSB +: SPK_AW];
        neur_idx = addr[WORD_LSB +: NEUR_AW];
        syn_idx  = addr[WORD_LSB +: SYN_AW];
    end

endmodule

// File: rtl/tinyodin_obi_responder.sv
// OBI slave front-end of tinyODIN: SRAM strobes, control register, start pulse, busy stall.
module tinyodin_obi_responder
    import tinyodin_pkg::*;
#(
    parameter int unsigned N      = 256,
    parameter int unsigned SPK_AW = 6,
    parameter int unsigned SYN_AW = 13,
    parameter type         req_t  = obi_pkg::obi_req_t,
    parameter type         rsp_t  = obi_pkg::obi_resp_t
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  req_t                 tinyODIN_slave_req_i,
    output rsp_t                 tinyODIN_slave_resp_o,
    output logic                 spk_cs_o,
    output logic                 spk_we_o,
    output logic [SPK_AW-1:0]    spk_addr_o,
    output logic                 neur_cs_o,
    output logic                 neur_we_o,
    output logic [$clog2(N)-1:0] neur_addr_o,
    output logic                 syn_cs_o,
    output logic                 syn_we_o,
    output logic [SYN_AW-1:0]    syn_addr_o,
    output logic [DATA_W-1:0]    mem_wdata_o,
    input  logic [DATA_W-1:0]    spk_rdata_i,
    input  logic [DATA_W-1:0]    neur_rdata_i,
    input  logic [DATA_W-1:0]    syn_rdata_i,
    output logic [DATA_W-1:0]    ctrl_o,
    output logic                 start_o,
    input  logic                 core_busy_i
);

    localparam int unsigned NEUR_AW = $clog2(N);

    state_t              state_q, state_d;
    region_t             region, region_q;
    logic                unmapped, unmapped_q, we_q;
    logic [SPK_AW-1:0]   spk_idx;
    logic [NEUR_AW-1:0]  neur_idx;
    logic [SYN_AW-1:0]   syn_idx;
    logic                is_sram, gnt, rvalid, ctrl_wr;
    logic [DATA_W-1:0]   resp_rdata, rdata_q, ctrl_q;
    logic                start_q;

    // Every write is a full word, so byte enables carry no information here.
    logic unused_be;
    assign unused_be = ^tinyODIN_slave_req_i.be;

    tinyodin_addr_decode #(
        .SPK_AW  (SPK_AW),
        .NEUR_AW (NEUR_AW),
        .SYN_AW  (SYN_AW)
    ) u_addr_decode (
        .addr     (tinyODIN_slave_req_i.addr),
        .region   (region),
        .unmapped (unmapped),
        .spk_idx  (spk_idx),
        .neur_idx (neur_idx),
        .syn_idx  (syn_idx)
    );

    assign ctrl_o  = ctrl_q;
    assign start_o = start_q;
    assign ctrl_wr = gnt && !unmapped && (region == REG_CTRL) && tinyODIN_slave_req_i.we;

    // Response FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant, SRAM strobes for the cycle-0 request, and the cycle-1 response.
    always_comb begin
        state_d               = ST_IDLE;
        spk_cs_o              = 1'b0;
        spk_we_o              = 1'b0;
        spk_addr_o            = '0;
        neur_cs_o             = 1'b0;
        neur_we_o             = 1'b0;
        neur_addr_o           = '0;
        syn_cs_o              = 1'b0;
        syn_we_o              = 1'b0;
        syn_addr_o            = '0;
        mem_wdata_o           = '0;
        resp_rdata            = '0;
        tinyODIN_slave_resp_o = '0;

        is_sram = !unmapped && (region != REG_CTRL);
        gnt     = !RST && tinyODIN_slave_req_i.req && !(core_busy_i && is_sram);

        if (gnt) begin
            state_d = ST_RESP;
            if (is_sram) begin
                mem_wdata_o = tinyODIN_slave_req_i.wdata;
                case (region)
                    REG_SPK: begin
                        spk_cs_o   = 1'b1;
                        spk_we_o   = tinyODIN_slave_req_i.we;
                        spk_addr_o = spk_idx;
                    end
                    REG_NEUR: begin
                        neur_cs_o   = 1'b1;
                        neur_we_o   = tinyODIN_slave_req_i.we;
                        neur_addr_o = neur_idx;
                    end
                    REG_SYN: begin
                        syn_cs_o   = 1'b1;
                        syn_we_o   = tinyODIN_slave_req_i.we;
                        syn_addr_o = syn_idx;
                    end
                    default: ;
                endcase
            end
        end

        if (we_q) begin
            resp_rdata = '0;
        end else if (unmapped_q) begin
            resp_rdata = UNMAPPED_RDATA;
        end else begin
            case (region_q)
                REG_SPK:  resp_rdata = spk_rdata_i;
                REG_NEUR: resp_rdata = neur_rdata_i;
                REG_SYN:  resp_rdata = syn_rdata_i;
                default:  resp_rdata = ctrl_view(ctrl_q, core_busy_i);
            endcase
        end

        rvalid                       = !RST && (state_q == ST_RESP);
        tinyODIN_slave_resp_o.gnt    = gnt;
        tinyODIN_slave_resp_o.rvalid = rvalid;
        tinyODIN_slave_resp_o.rdata  = RST ? '0 : (rvalid ? resp_rdata : rdata_q);
    end

    // Request attributes, control register, start pulse and held read data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            region_q   <= REG_SPK;
            we_q       <= 1'b0;
            unmapped_q <= 1'b0;
            ctrl_q     <= '0;
            start_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            start_q <= 1'b0;
            if (gnt) begin
                region_q   <= region;
                we_q       <= tinyODIN_slave_req_i.we;
                unmapped_q <= unmapped;
            end
            if (ctrl_wr) begin
                ctrl_q  <= tinyODIN_slave_req_i.wdata & ~CTRL_START_MASK;
                start_q <= tinyODIN_slave_req_i.wdata[CTRL_START_BIT] && !core_busy_i;
            end
            if (rvalid) begin
                rdata_q <= resp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_tinyodin_obi_responder.sv
// Randomized self-checking bench for tinyodin_obi_responder with a transaction-level model.
module tb_tinyodin_obi_responder;

    logic              clk;
    logic              rst;
    obi_pkg::obi_req_t  req_s;
    obi_pkg::obi_resp_t rsp_s;
    logic              spk_cs, spk_we, neur_cs, neur_we, syn_cs, syn_we;
    logic [5:0]        spk_addr;
    logic [7:0]        neur_addr;
    logic [12:0]       syn_addr;
    logic [31:0]       mem_wdata, spk_rdata, neur_rdata, syn_rdata, ctrl;
    logic              start, core_busy;
    logic              mem_init;

    int n_cmp = 0;
    int n_err = 0;

    tinyodin_obi_responder dut (
        .CLK                   (clk),
        .RST                   (rst),
        .tinyODIN_slave_req_i  (req_s),
        .tinyODIN_slave_resp_o (rsp_s),
        .spk_cs_o              (spk_cs),
        .spk_we_o              (spk_we),
        .spk_addr_o            (spk_addr),
        .neur_cs_o             (neur_cs),
        .neur_we_o             (neur_we),
        .neur_addr_o           (neur_addr),
        .syn_cs_o              (syn_cs),
        .syn_we_o              (syn_we),
        .syn_addr_o            (syn_addr),
        .mem_wdata_o           (mem_wdata),
        .spk_rdata_i           (spk_rdata),
        .neur_rdata_i          (neur_rdata),
        .syn_rdata_i           (syn_rdata),
        .ctrl_o                (ctrl),
        .start_o               (start),
        .core_busy_i           (core_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int r, input int i);
        return (32'(r) << 28) ^ (32'(i) * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    // Single-port SRAM models: one-cycle read latency, write on cs&we.
    logic [31:0] spk_mem [64];
    logic [31:0] neur_mem[256];
    logic [31:0] syn_mem [8192];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8192; i++) begin
                if (i < 64)  spk_mem[i]  <= init_val(0, i);
                if (i < 256) neur_mem[i] <= init_val(1, i);
                syn_mem[i] <= init_val(2, i);
            end
            spk_rdata  <= '0;
            neur_rdata <= '0;
            syn_rdata  <= '0;
        end else begin
            if (spk_cs)  begin if (spk_we)  spk_mem[spk_addr]   <= mem_wdata; else spk_rdata  <= spk_mem[spk_addr];   end
            if (neur_cs) begin if (neur_we) neur_mem[neur_addr] <= mem_wdata; else neur_rdata <= neur_mem[neur_addr]; end
            if (syn_cs)  begin if (syn_we)  syn_mem[syn_addr]   <= mem_wdata; else syn_rdata  <= syn_mem[syn_addr];   end
        end
    end

    // Reference model state: memory images, control register, pending response.
    logic [31:0] sh_spk[64];
    logic [31:0] sh_neur[256];
    logic [31:0] sh_syn[8192];
    logic [31:0] m_ctrl, m_val, m_last;
    bit          m_pend, m_ctrl_rd, m_start, prev_rst;
    bit          obs_gnt, obs_rvalid;
    int          ngnt, nrv;
    logic [31:0] ra;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, then compare every output against the model.
    task automatic step(input bit rs, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit busy);
        logic [31:0] exp_rd;
        logic [5:0]  strb;
        bit          mapped, sram, g;
        int          rg, idx;
        @(posedge clk);
        #1;
        rst         = rs;
        req_s.req   = rs ? 1'b0 : r;
        req_s.we    = w;
        req_s.be    = 4'($urandom);
        req_s.addr  = a;
        req_s.wdata = d;
        core_busy   = busy;
        #1;
        obs_gnt    = rsp_s.gnt;
        obs_rvalid = rsp_s.rvalid;
        if (rs) begin
            if (prev_rst) begin
                check("rst_gnt",    64'(rsp_s.gnt), 64'd0);
                check("rst_strobe", 64'({spk_cs, spk_we, neur_cs, neur_we, syn_cs, syn_we}), 64'd0);
                check("rst_addr",   64'({spk_addr, neur_addr, syn_addr}), 64'd0);
                check("rst_wdata",  64'(mem_wdata), 64'd0);
                check("rst_rvalid", 64'(rsp_s.rvalid), 64'd0);
                check("rst_rdata",  64'(rsp_s.rdata), 64'd0);
                check("rst_start",  64'(start), 64'd0);
                check("rst_ctrl",   64'(ctrl), 64'd0);
            end
            m_pend = 0; m_start = 0; m_ctrl = '0; m_last = '0; m_ctrl_rd = 0;
            prev_rst = 1;
            return;
        end
        prev_rst = 0;

        exp_rd = m_pend ? (m_ctrl_rd ? (m_ctrl | (busy ? 32'h400 : 32'h0)) : m_val) : m_last;
        check("rvalid", 64'(rsp_s.rvalid), 64'(m_pend));
        check("rdata",  64'(rsp_s.rdata), 64'(exp_rd));
        if (m_pend) m_last = exp_rd;
        check("start", 64'(start), 64'(m_start));
        check("ctrl",  64'(ctrl), 64'(m_ctrl));

        mapped = (a >> 22) == 0;
        rg     = int'((a >> 20) % 4);
        sram   = mapped && rg != 3;
        g      = r && !(busy && sram);
        check("gnt", 64'(rsp_s.gnt), 64'(g));
        strb = '0;
        if (g && sram) strb = 6'((w ? 3 : 2) << (2 * (2 - rg)));
        check("strobes", 64'({spk_cs, spk_we, neur_cs, neur_we, syn_cs, syn_we}), 64'(strb));
        if (g && sram) begin
            check("wdata", 64'(mem_wdata), 64'(d));
            case (rg)
                0: begin idx = int'((a >> 2) % 64);   check("spk_addr",  64'(spk_addr),  64'(idx)); end
                1: begin idx = int'((a >> 2) % 256);  check("neur_addr", 64'(neur_addr), 64'(idx)); end
                default: begin idx = int'((a >> 2) % 8192); check("syn_addr", 64'(syn_addr), 64'(idx)); end
            endcase
        end else begin
            idx = 0;
        end

        m_pend = g; m_start = 0; m_ctrl_rd = 0; m_val = '0;
        if (g) begin
            if (!mapped) begin
                m_val = w ? 32'h0 : 32'hDEAD_BEEF;
            end else if (rg == 3) begin
                if (w) begin
                    m_ctrl  = d & ~32'h400;
                    m_start = d[10] && !busy;
                end else begin
                    m_ctrl_rd = 1;
                end
            end else if (w) begin
                case (rg)
                    0: sh_spk[idx] = d;
                    1: sh_neur[idx] = d;
                    default: sh_syn[idx] = d;
                endcase
            end else begin
                case (rg)
                    0: m_val = sh_spk[idx];
                    1: m_val = sh_neur[idx];
                    default: m_val = sh_syn[idx];
                endcase
            end
        end
    endtask

    task automatic idle(input bit busy);
        step(0, 0, 0, 32'h0, 32'h0, busy);
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1; core_busy = 1'b0; req_s = '0;
        m_pend = 0; m_start = 0; m_ctrl = '0; m_last = '0; m_val = '0; m_ctrl_rd = 0; prev_rst = 0;
        for (int i = 0; i < 8192; i++) begin
            if (i < 64)  sh_spk[i]  = init_val(0, i);
            if (i < 256) sh_neur[i] = init_val(1, i);
            sh_syn[i] = init_val(2, i);
        end
        @(posedge clk);
        #1 mem_init = 1'b0;
        repeat (3) step(1, 0, 0, 32'h0, 32'h0, 0);

        // Neuron write
        step(0, 1, 1, 32'h0010_03FC, 32'h0015_E000, 0);
        check("t1_cs_we", 64'({neur_cs, neur_we}), 64'd3);
        check("t1_naddr", 64'(neur_addr), 64'hFF);
        idle(0);
        check("t1_rvalid", 64'(rsp_s.rvalid), 64'd1);
        check("t1_rdata",  64'(rsp_s.rdata), 64'd0);

        // Synapse read of index 4638 after placing a known word there
        step(0, 1, 1, 32'h0020_4878, 32'h1234_5678, 0);
        step(0, 1, 0, 32'h0020_4878, 32'h0, 0);
        check("t2_saddr", 64'(syn_addr), 64'd4638);
        idle(0);
        check("t2_rdata", 64'(rsp_s.rdata), 64'h1234_5678);

        // Control write with START, then busy read-back
        step(0, 1, 1, 32'h0030_0000, 32'hFF00_0400, 0);
        idle(0);
        check("t3_start", 64'(start), 64'd1);
        check("t3_ctrl",  64'(ctrl), 64'hFF00_0000);
        idle(1);
        check("t3_start_off", 64'(start), 64'd0);
        step(0, 1, 0, 32'h0030_0000, 32'h0, 1);
        idle(1);
        check("t3_rdata", 64'(rsp_s.rdata), 64'hFF00_0400);
        // START dropped while busy, other fields still written
        step(0, 1, 1, 32'h0030_0000, 32'h0000_0C05, 1);
        idle(0);
        check("t3_nostart", 64'(start), 64'd0);
        check("t3_ctrl2",   64'(ctrl), 64'h0000_0805);

        // Busy stall on spike write, released in the same cycle
        step(0, 1, 1, 32'h0000_0010, 32'hCAFE_0001, 1);
        check("t4_stall", 64'({rsp_s.gnt, spk_cs}), 64'd0);
        step(0, 1, 1, 32'h0000_0010, 32'hCAFE_0001, 1);
        step(0, 1, 1, 32'h0000_0010, 32'hCAFE_0001, 0);
        check("t4_gnt",  64'(rsp_s.gnt), 64'd1);
        check("t4_addr", 64'(spk_addr), 64'd4);
        idle(0);

        // Back-to-back spike writes
        ngnt = 0; nrv = 0;
        for (int k = 0; k < 65; k++) begin
            if (k < 64) step(0, 1, 1, 32'(k * 4), $urandom, 0);
            else idle(0);
            ngnt += int'(obs_gnt);
            nrv  += int'(obs_rvalid);
        end
        check("t5_gnts",   64'(ngnt), 64'd64);
        check("t5_rvalids", 64'(nrv), 64'd64);

        // Unmapped read, then reset while a response is pending
        step(0, 1, 0, 32'h0040_0000, 32'h0, 1);
        check("t6_gnt", 64'({rsp_s.gnt, spk_cs, neur_cs, syn_cs}), 64'h8);
        step(0, 1, 0, 32'h0010_0040, 32'h0, 0);
        check("t6_rdata", 64'(rsp_s.rdata), 64'hDEAD_BEEF);
        step(1, 0, 0, 32'h0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 32'h0, 0);
        idle(0);
        check("t6_rvalid", 64'(rsp_s.rvalid), 64'd0);

        // Random traffic across all regions
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 249) == 0) begin
                step(1, 0, 0, 32'h0, 32'h0, 0);
                step(1, 0, 0, 32'h0, 32'h0, 0);
            end else begin
                ra = $urandom & 32'h003F_FFFF;
                if ($urandom_range(0, 7) == 0) ra = ra | (32'($urandom_range(1, 1023)) << 22);
                step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, ra, $urandom,
                     $urandom_range(0, 9) < 3);
            end
        end
        idle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
